// File: rtl/line_buffer_sequencer_pkg.sv
// Shared definitions for the line-buffer sequencer: FSM states, kernel size codes and
// the rows-needed-per-kernel helper.
package line_buffer_sequencer_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StWait,
        StWrite,
        StEmit,
        StRealign,
        StNextRow,
        StDone
    } state_e;

    localparam logic [1:0] Size2x2     = 2'd0;
    localparam logic [1:0] Size3x3     = 2'd1;
    localparam logic [1:0] SizeIllegal = 2'd2;
    localparam logic [1:0] Size5x5     = 2'd3;

    // Kernel height K: rows that must be resident before the first window is valid.
    function automatic logic [2:0] k_from_size(input logic [1:0] size);
        logic [2:0] k;
        case (size)
            Size2x2: k = 3'd2;
            Size3x3: k = 3'd3;
            Size5x5: k = 3'd5;
            default: k = 3'd0;
        endcase
        return k;
    endfunction

endpackage

// File: rtl/line_buffer_sequencer_word_fetch.sv
// Single-outstanding word reader: issues a read request, forms the frame-memory word
// address and captures the returned word.
module line_buffer_sequencer_word_fetch #(
    parameter int unsigned IMG_WIDTH = 320,
    parameter int unsigned ADDR_W    = 20
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              fetch_i,
    input  logic [8:0]        row_i,
    input  logic [6:0]        word_i,
    input  logic              rd_valid_i,
    input  logic [31:0]       rd_data_i,
    output logic              rd_req_o,
    output logic [ADDR_W-1:0] rd_addr_o,
    output logic [31:0]       data_o,
    output logic              captured_o
);

    localparam int unsigned WordsPerRow = IMG_WIDTH / 4;

    logic        waiting_q, waiting_d;
    logic [31:0] data_q, data_d;

    assign rd_req_o   = fetch_i;
    assign rd_addr_o  = ADDR_W'(32'(row_i) * WordsPerRow + 32'(word_i));
    // Only a response to our own outstanding request is accepted.
    assign captured_o = waiting_q & rd_valid_i;
    assign data_o     = data_q;

    always_comb begin
        waiting_d = waiting_q;
        data_d    = data_q;
        if (fetch_i) begin
            waiting_d = 1'b1;
        end else if (captured_o) begin
            waiting_d = 1'b0;
            data_d    = rd_data_i;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            waiting_q <= 1'b0;
            data_q    <= '0;
        end else begin
            waiting_q <= waiting_d;
            data_q    <= data_d;
        end
    end

endmodule

// File: rtl/line_buffer_sequencer.sv
// Line-buffer sequencer: primes K rows from frame memory, then steps windows to the
// convolution unit. Optional stall counter enabled by LBSEQ_STALL_CNT_EN.
module line_buffer_sequencer
    import line_buffer_sequencer_pkg::*;
#(
    parameter int unsigned IMG_WIDTH  = 320,
    parameter int unsigned IMG_HEIGHT = 240,
    parameter int unsigned LINE_BYTES = 512,
    parameter int unsigned ADDR_W     = 20
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              start_i,
    input  logic [1:0]        size_i,
    output logic              rd_req_o,
    output logic [ADDR_W-1:0] rd_addr_o,
    input  logic              rd_valid_i,
    input  logic [31:0]       rd_data_i,
    output logic [31:0]       lb_datain_o,
    output logic [8:0]        lb_address_o,
    output logic              lb_save_data_o,
    output logic              lb_next_matrix_o,
    output logic [1:0]        lb_size_o,
    output logic              mat_valid_o,
    input  logic              mat_ready_i,
    output logic [8:0]        mat_row_o,
    output logic [8:0]        mat_col_o,
`ifdef LBSEQ_STALL_CNT_EN
    output logic [31:0]       stall_cycles_o,
`endif
    output logic              busy_o,
    output logic              done_o,
    output logic              error_o
);

    localparam int unsigned RealignLen = LINE_BYTES - IMG_WIDTH;
    localparam logic [6:0]  LastWord   = 7'(IMG_WIDTH / 4 - 1);
    localparam logic [8:0]  LastCol    = 9'(IMG_WIDTH - 1);
    localparam logic [8:0]  LastRow    = 9'(IMG_HEIGHT - 1);
    localparam logic [8:0]  LastShift  = 9'(RealignLen - 1);

    state_e     state_q, state_d;
    logic [8:0] row_q, row_d;
    logic [6:0] word_q, word_d;
    logic [8:0] col_q, col_d;
    logic [8:0] shift_q, shift_d;
    logic [1:0] size_q, size_d;
    logic       error_q, error_d;
    logic       fetch;
    logic       captured;
    logic       realign;
    logic       frame_start;

    assign frame_start = (state_q == StIdle) && start_i && (size_i != SizeIllegal);

    line_buffer_sequencer_word_fetch #(
        .IMG_WIDTH (IMG_WIDTH),
        .ADDR_W    (ADDR_W)
    ) u_word_fetch (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .fetch_i    (fetch),
        .row_i      (row_q),
        .word_i     (word_q),
        .rd_valid_i (rd_valid_i),
        .rd_data_i  (rd_data_i),
        .rd_req_o   (rd_req_o),
        .rd_addr_o  (rd_addr_o),
        .data_o     (lb_datain_o),
        .captured_o (captured)
    );

    always_comb begin
        state_d        = state_q;
        row_d          = row_q;
        word_d         = word_q;
        col_d          = col_q;
        shift_d        = shift_q;
        size_d         = size_q;
        error_d        = 1'b0;
        fetch          = 1'b0;
        realign        = 1'b0;
        lb_save_data_o = 1'b0;
        mat_valid_o    = 1'b0;
        case (state_q)
            StIdle: begin
                if (start_i && (size_i == SizeIllegal)) begin
                    error_d = 1'b1;
                end else if (frame_start) begin
                    size_d  = size_i;
                    row_d   = '0;
                    word_d  = '0;
                    state_d = StFetch;
                end
            end
            StFetch: begin
                fetch   = 1'b1;
                state_d = StWait;
            end
            StWait: begin
                if (captured) state_d = StWrite;
            end
            StWrite: begin
                lb_save_data_o = 1'b1;
                if (word_q != LastWord) begin
                    word_d  = word_q + 7'd1;
                    state_d = StFetch;
                end else begin
                    word_d = '0;
                    if (row_q < {6'd0, k_from_size(size_q) - 3'd1}) begin
                        state_d = StNextRow;
                    end else begin
                        col_d   = '0;
                        state_d = StEmit;
                    end
                end
            end
            StEmit: begin
                mat_valid_o = 1'b1;
                if (mat_ready_i) begin
                    col_d = col_q + 9'd1;
                    if (col_q == LastCol) begin
                        shift_d = '0;
                        state_d = (RealignLen == 0) ? StNextRow : StRealign;
                    end
                end
            end
            StRealign: begin
                // Spin the rotation the rest of the way round so byte 0 lines up again.
                realign = 1'b1;
                if (shift_q == LastShift) begin
                    state_d = StNextRow;
                end else begin
                    shift_d = shift_q + 9'd1;
                end
            end
            StNextRow: begin
                if (row_q == LastRow) begin
                    state_d = StDone;
                end else begin
                    row_d   = row_q + 9'd1;
                    state_d = StFetch;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign lb_next_matrix_o = (mat_valid_o & mat_ready_i) | realign;
    assign lb_address_o     = (state_q == StWrite) ? {word_q, 2'b00} : 9'd0;
    assign lb_size_o        = size_q;
    assign mat_row_o        = row_q;
    assign mat_col_o        = col_q;
    assign busy_o           = (state_q != StIdle) && (state_q != StDone);
    assign done_o           = (state_q == StDone);
    assign error_o          = error_q;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= StIdle;
            row_q   <= '0;
            word_q  <= '0;
            col_q   <= '0;
            shift_q <= '0;
            size_q  <= '0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            word_q  <= word_d;
            col_q   <= col_d;
            shift_q <= shift_d;
            size_q  <= size_d;
            error_q <= error_d;
        end
    end

`ifdef LBSEQ_STALL_CNT_EN
    logic [31:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if (frame_start) begin
            stall_d = '0;
        end else if (mat_valid_o && !mat_ready_i && (stall_q != '1)) begin
            stall_d = stall_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cycles_o = stall_q;
`endif

endmodule

// File: tb/tb_line_buffer_sequencer.sv
// Scoreboard bench for line_buffer_sequencer on an 8x4 image with 16-byte line buffers.
module tb_line_buffer_sequencer;

    localparam int unsigned W  = 8;
    localparam int unsigned H  = 4;
    localparam int unsigned LB = 16;
    localparam int unsigned AW = 20;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [1:0]    size = 2'd0;
    logic          rd_req;
    logic [AW-1:0] rd_addr;
    logic          rd_valid;
    logic [31:0]   rd_data;
    logic [31:0]   lb_datain;
    logic [8:0]    lb_address;
    logic          lb_save_data;
    logic          lb_next_matrix;
    logic [1:0]    lb_size;
    logic          mat_valid;
    logic          mat_ready = 1'b1;
    logic [8:0]    mat_row;
    logic [8:0]    mat_col;
    logic          busy;
    logic          done;
    logic          error;
`ifdef LBSEQ_STALL_CNT_EN
    logic [31:0]   stall_cycles;
`endif

    always #5 clk = ~clk;

    line_buffer_sequencer #(
        .IMG_WIDTH  (W),
        .IMG_HEIGHT (H),
        .LINE_BYTES (LB),
        .ADDR_W     (AW)
    ) dut (
        .clk_i            (clk),
        .reset_i          (reset),
        .start_i          (start),
        .size_i           (size),
        .rd_req_o         (rd_req),
        .rd_addr_o        (rd_addr),
        .rd_valid_i       (rd_valid),
        .rd_data_i        (rd_data),
        .lb_datain_o      (lb_datain),
        .lb_address_o     (lb_address),
        .lb_save_data_o   (lb_save_data),
        .lb_next_matrix_o (lb_next_matrix),
        .lb_size_o        (lb_size),
        .mat_valid_o      (mat_valid),
        .mat_ready_i      (mat_ready),
        .mat_row_o        (mat_row),
        .mat_col_o        (mat_col),
`ifdef LBSEQ_STALL_CNT_EN
        .stall_cycles_o   (stall_cycles),
`endif
        .busy_o           (busy),
        .done_o           (done),
        .error_o          (error)
    );

    int errors = 0;
    int checks = 0;

    logic [AW-1:0] aq[$];
    logic [40:0]   sq[$];
    logic [17:0]   wq[$];
    int            rq[$];
    logic [1:0]    exp_size = 2'd0;
    int            lat = 1;
    int            done_cnt = 0;
    int            overlap = 0;
    int            nm_cnt = 0;
    int            rd_cnt = 0;
    bit            first = 1'b1;

    function automatic logic [31:0] mem_word(input logic [AW-1:0] a);
        return {8'hA0 + a[7:0], 8'h30 + a[7:0], 8'h20 + a[7:0], 8'h10 + a[7:0]};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic fail(input string nm);
        checks++;
        errors++;
        $display("FAIL %s: got event expected none", nm);
    endtask

    task automatic row_boundary();
        if (rq.size() == 0) fail("row_count_unexpected");
        else chk("next_matrix_per_row", 64'(nm_cnt), 64'(rq.pop_front()));
        nm_cnt = 0;
    endtask

    // Monitor: compares DUT activity against the expectation queues.
    always @(negedge clk) begin
        if (reset) begin
            first  = 1'b1;
            nm_cnt = 0;
        end else begin
            if (rd_req) begin
                rd_cnt++;
                if (aq.size() == 0) fail("rd_req_unexpected");
                else chk("rd_addr", 64'(rd_addr), 64'(aq.pop_front()));
            end
            if (lb_save_data && lb_next_matrix) overlap++;
            if (lb_save_data) begin
                if (lb_address == 9'd0) begin
                    if (!first) row_boundary();
                    first = 1'b0;
                end
                if (sq.size() == 0) fail("save_unexpected");
                else chk("write_addr_data", 64'({lb_address, lb_datain}), 64'(sq.pop_front()));
                chk("lb_size", 64'(lb_size), 64'(exp_size));
            end
            if (lb_next_matrix) nm_cnt++;
            if (mat_valid && wq.size() == 0) fail("mat_valid_priming");
            if (mat_valid && mat_ready && wq.size() != 0)
                chk("window_row_col", 64'({mat_row, mat_col}), 64'(wq.pop_front()));
            if (done) begin
                done_cnt++;
                row_boundary();
                first = 1'b1;
            end
        end
    end

    // Frame memory: one outstanding read, response after lat cycles.
    initial begin
        logic [AW-1:0] a;
        rd_valid = 1'b0;
        rd_data  = '0;
        forever begin
            @(negedge clk);
            if (rd_req && !reset) begin
                a = rd_addr;
                repeat (lat) @(posedge clk);
                #1;
                rd_valid = 1'b1;
                rd_data  = mem_word(a);
                @(posedge clk);
                #1;
                rd_valid = 1'b0;
                rd_data  = 32'hDEAD_BEEF;
            end
        end
    end

    task automatic push_expect(input logic [1:0] sz);
        int k;
        k = (sz == 2'd0) ? 2 : (sz == 2'd1) ? 3 : 5;
        for (int r = 0; r < int'(H); r++) begin
            for (int w = 0; w < int'(W / 4); w++) begin
                aq.push_back(AW'(r * int'(W / 4) + w));
                sq.push_back({9'(w * 4), mem_word(AW'(r * int'(W / 4) + w))});
            end
            rq.push_back((r >= k - 1) ? int'(LB) : 0);
            if (r >= k - 1)
                for (int c = 0; c < int'(W); c++) wq.push_back({9'(r), 9'(c)});
        end
        exp_size = sz;
    endtask

    task automatic start_frame(input logic [1:0] sz);
        push_expect(sz);
        done_cnt = 0;
        @(posedge clk);
        #1;
        start = 1'b1;
        size  = sz;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (done_cnt == 0 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        chk("done_seen", 64'(done_cnt != 0), 64'd1);
        repeat (3) @(posedge clk);
        #1;
        chk("done_once", 64'(done_cnt), 64'd1);
        chk("busy_after_done", 64'(busy), 64'd0);
        chk("reads_left", 64'(aq.size()), 64'd0);
        chk("writes_left", 64'(sq.size()), 64'd0);
        chk("windows_left", 64'(wq.size()), 64'd0);
        chk("rows_left", 64'(rq.size()), 64'd0);
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, "_ctrl"}, 64'({rd_req, lb_save_data, lb_next_matrix, mat_valid, busy, done,
                                error, lb_size}), 64'd0);
        chk({nm, "_data"}, 64'({rd_addr, lb_datain}), 64'd0);
        chk({nm, "_idx"}, 64'({lb_address, mat_row, mat_col}), 64'd0);
    endtask

    initial begin
        int n;
        int rc;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        chk_all_zero("reset");

        // Illegal size: error pulse only.
        rc = rd_cnt;
        @(posedge clk);
        #1;
        start = 1'b1;
        size  = 2'd2;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("error_pulse", 64'(error), 64'd1);
        chk("error_busy", 64'(busy), 64'd0);
        @(posedge clk);
        #1;
        chk("error_one_cycle", 64'(error), 64'd0);
        repeat (5) @(posedge clk);
        #1;
        chk("error_no_rd_req", 64'(rd_cnt), 64'(rc));

        // 3x3, read latency 1.
        lat = 1;
        start_frame(2'd1);
        wait_done();

        // 3x3, read latency 7, plus a start pulse while busy.
        lat = 7;
        start_frame(2'd1);
        repeat (20) @(posedge clk);
        #1;
        start = 1'b1;
        size  = 2'd0;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done();

        // 2x2 with consumer stalled 5 cycles at column 3.
        lat = 2;
        start_frame(2'd0);
        n = 0;
        while (!(mat_valid && mat_col == 9'd3) && n < 2000) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("stall_reached", 64'(mat_valid && mat_col == 9'd3), 64'd1);
        mat_ready = 1'b0;
        repeat (5) begin
            @(negedge clk);
            chk("stall_col_held", 64'(mat_col), 64'd3);
            chk("stall_no_shift", 64'(lb_next_matrix), 64'd0);
        end
        @(posedge clk);
        #1;
        mat_ready = 1'b1;
        wait_done();
`ifdef LBSEQ_STALL_CNT_EN
        chk("stall_cycles", 64'(stall_cycles), 64'd5);
`endif

        // 5x5 on a 4-row image: never enough rows for a window.
        lat = 1;
        start_frame(2'd3);
        wait_done();

        // Reset in the middle of emitting, then a full clean frame.
        start_frame(2'd1);
        n = 0;
        while (!mat_valid && n < 2000) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("abort_reached_emit", 64'(mat_valid), 64'd1);
        reset = 1'b1;
        #1;
        chk_all_zero("abort");
        aq.delete();
        sq.delete();
        wq.delete();
        rq.delete();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        start_frame(2'd1);
        wait_done();

        chk("no_save_shift_overlap", 64'(overlap), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
